// File: rtl/fp_align_ctrl.sv
// fp_align_ctrl: exponent compare and mantissa alignment controller.
// Accepts an operand pair, selects the larger exponent, then right-shifts
// the smaller operand's mantissa one bit per cycle until it is aligned.
// Optional feature macro: FP_ALIGN_STICKY_EN builds the sticky-bit tracker;
// without it, sticky is tied to 0.
module fp_align_ctrl #(
    parameter int EXP_MAX_W = 16,
    parameter int MAN_W     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_MAX_W-1:0] e_a,
    input  logic [EXP_MAX_W-1:0] e_b,
    input  logic [MAN_W-1:0]     m_a,
    input  logic [MAN_W-1:0]     m_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_MAX_W-1:0] e_out,
    output logic [MAN_W-1:0]     m_large,
    output logic [MAN_W-1:0]     m_small,
    output logic                 swap,
    output logic                 sticky,
    output logic                 busy
);

    localparam int DW = EXP_MAX_W + 1;      // difference width, never overflows
    localparam int CW = $clog2(MAN_W + 1);  // shift counter width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIFF  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [EXP_MAX_W-1:0] ea_q, ea_d, eb_q, eb_d;
    logic [MAN_W-1:0]     ma_q, ma_d, mb_q, mb_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [EXP_MAX_W-1:0] e_out_q, e_out_d;
    logic [MAN_W-1:0]     m_large_q, m_large_d;
    logic [MAN_W-1:0]     m_small_q, m_small_d;
    logic                 swap_q, swap_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
`ifdef FP_ALIGN_STICKY_EN
    logic                 sticky_q, sticky_d;
`endif

    logic signed [DW-1:0] ea_x_s, eb_x_s;
    logic                 b_gt_a_s;
    logic [DW-1:0]        diff_s;
    logic [CW-1:0]        n_s;

    // Sign-extended exponent difference and clamped shift count.
    always_comb begin
        ea_x_s   = $signed({ea_q[EXP_MAX_W-1], ea_q});
        eb_x_s   = $signed({eb_q[EXP_MAX_W-1], eb_q});
        b_gt_a_s = (eb_x_s > ea_x_s);
        if (b_gt_a_s) begin
            diff_s = eb_x_s - ea_x_s;
        end else begin
            diff_s = ea_x_s - eb_x_s;
        end
        if (diff_s >= DW'(MAN_W)) begin
            n_s = CW'(MAN_W);
        end else begin
            n_s = diff_s[CW-1:0];
        end
    end

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_d   = state_q;
        ea_d      = ea_q;
        eb_d      = eb_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        cnt_d     = cnt_q;
        e_out_d   = e_out_q;
        m_large_d = m_large_q;
        m_small_d = m_small_q;
        swap_d    = swap_q;
`ifdef FP_ALIGN_STICKY_EN
        sticky_d  = sticky_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    ea_d     = e_a;
                    eb_d     = e_b;
                    ma_d     = m_a;
                    mb_d     = m_b;
`ifdef FP_ALIGN_STICKY_EN
                    sticky_d = 1'b0;
`endif
                    state_d  = ST_DIFF;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_DIFF: begin
                // On an exponent tie operand a is treated as the larger one.
                e_out_d   = b_gt_a_s ? eb_q : ea_q;
                m_large_d = b_gt_a_s ? mb_q : ma_q;
                m_small_d = b_gt_a_s ? ma_q : mb_q;
                swap_d    = b_gt_a_s;
                cnt_d     = n_s;
                if (n_s != {CW{1'b0}}) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                m_small_d = m_small_q >> 1;
`ifdef FP_ALIGN_STICKY_EN
                sticky_d  = sticky_q | m_small_q[0];
`endif
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ea_q        <= {EXP_MAX_W{1'b0}};
            eb_q        <= {EXP_MAX_W{1'b0}};
            ma_q        <= {MAN_W{1'b0}};
            mb_q        <= {MAN_W{1'b0}};
            cnt_q       <= {CW{1'b0}};
            e_out_q     <= {EXP_MAX_W{1'b0}};
            m_large_q   <= {MAN_W{1'b0}};
            m_small_q   <= {MAN_W{1'b0}};
            swap_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FP_ALIGN_STICKY_EN
            sticky_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            cnt_q       <= cnt_d;
            e_out_q     <= e_out_d;
            m_large_q   <= m_large_d;
            m_small_q   <= m_small_d;
            swap_q      <= swap_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef FP_ALIGN_STICKY_EN
            sticky_q    <= sticky_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign e_out     = e_out_q;
    assign m_large   = m_large_q;
    assign m_small   = m_small_q;
    assign swap      = swap_q;
`ifdef FP_ALIGN_STICKY_EN
    assign sticky    = sticky_q;
`else
    assign sticky    = 1'b0;
`endif

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Testbench for fp_align_ctrl: directed cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_fp_align_ctrl;

    localparam int EW = 16;
    localparam int MW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] e_a, e_b;
    logic [MW-1:0] m_a, m_b;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] e_out;
    logic [MW-1:0] m_large, m_small;
    logic          swap, sticky, busy;

    int checks   = 0;
    int failures = 0;

    fp_align_ctrl #(.EXP_MAX_W(EW), .MAN_W(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .e_a(e_a), .e_b(e_b), .m_a(m_a), .m_b(m_b),
        .out_valid(out_valid), .out_ready(out_ready), .e_out(e_out),
        .m_large(m_large), .m_small(m_small), .swap(swap),
        .sticky(sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            n;
        int            lat;
        logic [EW-1:0] eout;
        logic [MW-1:0] ml;
        logic [MW-1:0] ms;
        logic          sw;
        logic          st;
    } exp_t;

    // Reference: plain integer arithmetic on the operand pair.
    function automatic exp_t model_op(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                                      input logic [MW-1:0] ma, input logic [MW-1:0] mb);
        exp_t          r;
        int            a, b, d;
        logic [MW-1:0] sm;
        longint        mask;
        a      = int'($signed(ea));
        b      = int'($signed(eb));
        r.sw   = (b > a);
        d      = r.sw ? (b - a) : (a - b);
        r.n    = (d > MW) ? MW : d;
        r.lat  = 1 + r.n;
        r.eout = r.sw ? eb : ea;
        r.ml   = r.sw ? mb : ma;
        sm     = r.sw ? ma : mb;
        r.ms   = MW'(longint'(sm) >> r.n);
        mask   = (longint'(1) << r.n) - longint'(1);
`ifdef FP_ALIGN_STICKY_EN
        r.st   = ((longint'(sm) & mask) != 64'd0);
`else
        r.st   = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: pending operation, edges since acceptance, expected result.
    logic m_pend = 1'b0;
    int   m_cyc  = 0;
    exp_t m_exp;

    // Model update from the inputs presented at each edge.
    always @(posedge clk) begin
        if (rst) begin
            m_pend <= 1'b0;
            m_cyc  <= 0;
        end else if (!m_pend) begin
            if (in_valid) begin
                m_pend <= 1'b1;
                m_cyc  <= 0;
                m_exp  <= model_op(e_a, e_b, m_a, m_b);
            end
        end else if (m_cyc >= m_exp.lat && out_ready) begin
            m_pend <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        logic exp_ov;
        exp_ov = m_pend && (m_cyc >= m_exp.lat);
        chk("in_ready", 64'(in_ready), 64'(!m_pend));
        chk("busy", 64'(busy), 64'(m_pend));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("e_out", 64'(e_out), 64'(m_exp.eout));
            chk("m_large", 64'(m_large), 64'(m_exp.ml));
            chk("m_small", 64'(m_small), 64'(m_exp.ms));
            chk("swap", 64'(swap), 64'(m_exp.sw));
            chk("sticky", 64'(sticky), 64'(m_exp.st));
        end
    end

    task automatic chk_reset_state(input string nm);
        chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_e_out"}, 64'(e_out), 64'd0);
        chk({nm, "_m_large"}, 64'(m_large), 64'd0);
        chk({nm, "_m_small"}, 64'(m_small), 64'd0);
        chk({nm, "_swap"}, 64'(swap), 64'd0);
        chk({nm, "_sticky"}, 64'(sticky), 64'd0);
    endtask

    // Accept one pair, wait for the result, compare to literals, optionally drain.
    task automatic run_op(input string nm, input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                          input logic [MW-1:0] ma, input logic [MW-1:0] mb, input int lat,
                          input logic [EW-1:0] eo, input logic [MW-1:0] ml,
                          input logic [MW-1:0] ms, input logic sw, input logic st,
                          input bit drain);
        int k;
        e_a = ea; e_b = eb; m_a = ma; m_b = mb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        e_a = EW'($urandom); e_b = EW'($urandom);
        m_a = MW'($urandom); m_b = MW'($urandom);
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_latency"}, 64'(k), 64'(lat));
        chk({nm, "_e_out"}, 64'(e_out), 64'(eo));
        chk({nm, "_m_large"}, 64'(m_large), 64'(ml));
        chk({nm, "_m_small"}, 64'(m_small), 64'(ms));
        chk({nm, "_swap"}, 64'(swap), 64'(sw));
        chk({nm, "_sticky"}, 64'(sticky), 64'(st));
        if (drain) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic st_swap, st_clamp, st_ext;
        logic [EW-1:0] hold_e;
        int mode;
`ifdef FP_ALIGN_STICKY_EN
        st_swap = 1'b1; st_clamp = 1'b1; st_ext = 1'b1;
`else
        st_swap = 1'b0; st_clamp = 1'b0; st_ext = 1'b0;
`endif
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        e_a = '0; e_b = '0; m_a = '0; m_b = '0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op("tie", 16'd5, 16'd5, 24'h800000, 24'hC00000, 1,
               16'd5, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b1);
        run_op("swap", 16'd3, 16'd7, 24'h800001, 24'h900000, 5,
               16'd7, 24'h900000, 24'h080000, 1'b1, st_swap, 1'b1);
        run_op("clamp", 16'hFFF6, 16'd20, 24'hA00000, 24'hB00000, 25,
               16'd20, 24'hB00000, 24'h000000, 1'b1, st_clamp, 1'b1);
        run_op("extreme", 16'h7FFF, 16'h8000, 24'h123456, 24'hFFFFFF, 25,
               16'h7FFF, 24'h123456, 24'h000000, 1'b0, st_ext, 1'b1);

        // Backpressure: hold DONE while new operands are offered.
        run_op("bp", 16'd2, 16'd0, 24'hF00000, 24'h00000F, 3,
               16'd2, 24'hF00000, 24'h000003, 1'b0, st_swap, 1'b0);
        hold_e = e_out;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; e_a = 16'd100; e_b = 16'd1;
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_e_out", 64'(e_out), 64'd2);
            chk("bp_m_small", 64'(m_small), 64'h3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_hold_e", 64'(e_out), 64'(hold_e));
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        // Reset while shifting.
        e_a = 16'd0; e_b = 16'd10; m_a = 24'hABCDEF; m_b = 24'h800000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("midrst");
        @(negedge clk);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 6000; c++) begin
            mode = int'($urandom_range(0, 3));
            e_a = EW'($urandom);
            case (mode)
                0: e_b = EW'($urandom);
                1: e_b = e_a + EW'($urandom_range(0, 60)) - 16'd30;
                2: e_b = e_a;
                default: begin
                    e_a = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
                    e_b = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
                end
            endcase
            m_a = MW'($urandom);
            m_b = ($urandom_range(0, 3) == 0) ? MW'($urandom_range(0, 15)) : MW'($urandom);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_align_ctrl.md
FP_ALIGN_CTRL -- requirements
Module: fp_align_ctrl

Interface
REQ-001 SHALL have parameter EXP_MAX_W, default 16: signed exponent width.
REQ-002 SHALL have parameter MAN_W, default 24: mantissa width, hidden bit included.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port in_valid, input, 1: operand pair present.
REQ-006 SHALL have port in_ready, output, 1: block can accept an operand pair.
REQ-007 SHALL have ports e_a and e_b, input, EXP_MAX_W each: signed operand exponents.
REQ-008 SHALL have ports m_a and m_b, input, MAN_W each: unsigned operand mantissas.
REQ-009 SHALL have port out_valid, output, 1: aligned result present.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port e_out, output, EXP_MAX_W: larger exponent.
REQ-012 SHALL have port m_large, output, MAN_W: mantissa of the larger-exponent operand.
REQ-013 SHALL have port m_small, output, MAN_W: other mantissa, right-shifted by the exponent difference.
REQ-014 SHALL have port swap, output, 1: high when e_b > e_a.
REQ-015 SHALL have port sticky, output, 1: OR of all bits shifted out of m_small.
REQ-016 SHALL have port busy, output, 1: high in any state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, DIFF, SHIFT and DONE.
REQ-018 in_ready SHALL equal 1 only in IDLE; acceptance occurs on the edge where in_valid=1 and in_ready=1, latching e_a, e_b, m_a and m_b and entering DIFF.
REQ-019 DIFF SHALL compute diff = |e_a - e_b| in EXP_MAX_W+1 bits with signed arithmetic and no overflow.
- e_out = max(e_a, e_b) signed.
- swap = (e_b > e_a).
- On a tie, a is the larger operand and swap=0.
REQ-020 The DIFF-exit edge SHALL load the shift count n = min(diff, MAN_W), then go to SHIFT if n != 0, else DONE.
REQ-021 Each SHIFT edge SHALL shift m_small right 1 bit, zero-filled, and decrement n; the edge on which n reaches 0 SHALL enter DONE.
REQ-022 out_valid SHALL first be high 1+n cycles after the acceptance edge.
REQ-023 In DONE, out_valid SHALL be 1 and all result outputs SHALL be held stable until out_ready=1.
REQ-024 On the out_valid & out_ready edge the block SHALL return to IDLE; no pipelining, so a new operand is accepted no earlier than the following edge.
REQ-025 in_valid SHALL be ignored outside IDLE, and operand inputs SHALL be don't-care after acceptance.
REQ-026 diff >= MAN_W SHALL yield m_small = 0 after exactly MAN_W shift cycles.

Reset
REQ-027 rst=1 on any edge SHALL force IDLE regardless of state, including mid-SHIFT or DONE, and SHALL discard any in-flight operation.
REQ-028 Reset values SHALL be: in_ready=1 (IDLE), out_valid=0, busy=0, e_out=0, m_large=0, m_small=0, swap=0, sticky=0.
REQ-029 rst SHALL override simultaneous in_valid or out_ready.

Configuration
REQ-030 Macro FP_ALIGN_STICKY_EN SHALL control sticky.
- Defined: sticky is cleared at acceptance and ORs in each shifted-out LSB; with diff >= MAN_W it equals |original m_small|.
- Undefined: sticky is constant 0 and no sticky logic is built; all other behaviour is identical.

Verification (MAN_W=24, EXP_MAX_W=16, FP_ALIGN_STICKY_EN defined unless noted)
REQ-031 Tie: e_a=5, e_b=5, m_a=0x800000, m_b=0xC00000 -> out_valid 1 cycle after acceptance; e_out=5, swap=0, m_large=0x800000, m_small=0xC00000, sticky=0.
REQ-032 Swap: e_a=3, e_b=7, m_a=0x800001, m_b=0x900000 -> out_valid after 5 cycles; e_out=7, swap=1, m_large=0x900000, m_small=0x080000, sticky=1 (sticky=0 with the macro undefined).
REQ-033 Clamp: e_a=-10, e_b=20, m_a=0xA00000 -> out_valid after 25 cycles; m_small=0, sticky=1, e_out=20, swap=1.
REQ-034 Extremes: e_a=0x7FFF, e_b=0x8000 -> diff=65535 computed without wrap; e_out=0x7FFF, swap=0, n=24.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 -> outputs stable, in_ready=0, no new acceptance; accept on the out_ready edge, then in_ready=1 on the next cycle.
REQ-036 Reset mid-operation: rst=1 for 1 cycle during SHIFT -> next cycle IDLE, out_valid=0, busy=0, in_ready=1, all result outputs 0.
